ir_nec_decoder: RTL and testbench

//  Decodes NEC-format remote frames from the DE2-115 IR receiver (IRDA_RXD, idle high, burst = low).

---
 rtl/ir_nec_decoder.sv | 194 +++++++++++++++++++
 tb/tb_ir_nec_decoder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ir_nec_decoder.sv
// NEC infrared remote decoder. It measures the pulse widths on the synchronised
// receiver line in 10 us ticks and decodes leader, data, stop and repeat codes.
module ir_nec_decoder #(
  parameter int CLK_HZ   = 50_000_000,
  parameter bit EXT_ADDR = 1'b0
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic       IRDA_RXD,
  output logic [7:0] ir_button,
  output logic [7:0] ir_addr,
  output logic       ir_valid,
  output logic       ir_repeat,
  output logic       ir_error,
  output logic       ir_busy
);

  localparam int          TICK_TC  = CLK_HZ / 100_000;
  localparam logic [15:0] PRE_LAST = 16'(TICK_TC - 1);

  typedef enum logic [2:0] {
    IDLE,
    LEAD_BURST,
    LEAD_SPACE,
    BIT_BURST,
    BIT_SPACE,
    STOP,
    REPEAT_BURST
  } state_t;

  state_t      r_state;
  logic [2:0]  r_sync;
  logic [15:0] r_pre;
  logic [10:0] r_dur;
  logic [31:0] r_sr;
  logic [5:0]  r_bitcnt;
  logic        r_have_frame;
  logic [7:0]  r_button;
  logic [7:0]  r_addr;
  logic        r_valid;
  logic        r_repeat;
  logic        r_error;

  logic        w_fall;
  logic        w_rise;
  logic        w_edge;
  logic [10:0] w_hi;
  logic        w_timeout;
  logic        w_cmd_ok;
  logic        w_addr_ok;

  function automatic logic in_win(input logic [10:0] d, input logic [10:0] lo,
                                  input logic [10:0] hi);
    return (d >= lo) && (d <= hi);
  endfunction

  // Sync flops reset low so a line already low at reset release never yields a fall.
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) r_sync <= 3'b000;
    else       r_sync <= {r_sync[1:0], IRDA_RXD};
  end

  assign w_fall = r_sync[2] & ~r_sync[1];
  assign w_rise = ~r_sync[2] & r_sync[1];
  assign w_edge = w_fall | w_rise;

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      r_pre <= 16'd0;
      r_dur <= 11'd0;
    end else if (w_edge) begin
      r_pre <= 16'd0;
      r_dur <= 11'd0;
    end else if (r_pre == PRE_LAST) begin
      r_pre <= 16'd0;
      if (r_dur != 11'h7FF) r_dur <= r_dur + 11'd1;
    end else begin
      r_pre <= r_pre + 16'd1;
    end
  end

  always_comb begin
    w_hi = 11'h7FF;
    case (r_state)
      LEAD_BURST:   w_hi = 11'd1000;
      LEAD_SPACE:   w_hi = 11'd500;
      BIT_BURST:    w_hi = 11'd72;
      BIT_SPACE:    w_hi = 11'd200;
      STOP:         w_hi = 11'd72;
      REPEAT_BURST: w_hi = 11'd72;
      default:      w_hi = 11'h7FF;
    endcase
  end

  assign w_timeout = (r_state != IDLE) && (r_dur > w_hi);
  assign w_cmd_ok  = ((r_sr[23:16] ^ r_sr[31:24]) == 8'hFF);
  assign w_addr_ok = ((r_sr[7:0] ^ r_sr[15:8]) == 8'hFF);

  // An unexpected edge, an out-of-window width or a timeout all abort to IDLE.
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_sr         <= 32'd0;
      r_bitcnt     <= 6'd0;
      r_have_frame <= 1'b0;
      r_button     <= 8'd0;
      r_addr       <= 8'd0;
      r_valid      <= 1'b0;
      r_repeat     <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_valid  <= 1'b0;
      r_repeat <= 1'b0;
      r_error  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_fall) r_state <= LEAD_BURST;
        end
        LEAD_BURST: begin
          if (w_rise && in_win(r_dur, 11'd800, 11'd1000)) begin
            r_state <= LEAD_SPACE;
          end else if (w_edge || w_timeout) begin
            r_state <= IDLE;
            r_error <= 1'b1;
          end
        end
        LEAD_SPACE: begin
          if (w_fall && in_win(r_dur, 11'd400, 11'd500)) begin
            r_state  <= BIT_BURST;
            r_bitcnt <= 6'd0;
          end else if (w_fall && in_win(r_dur, 11'd180, 11'd270)) begin
            r_state <= REPEAT_BURST;
          end else if (w_edge || w_timeout) begin
            r_state <= IDLE;
            r_error <= 1'b1;
          end
        end
        BIT_BURST: begin
          if (w_rise && in_win(r_dur, 11'd40, 11'd72)) begin
            r_state <= BIT_SPACE;
          end else if (w_edge || w_timeout) begin
            r_state <= IDLE;
            r_error <= 1'b1;
          end
        end
        BIT_SPACE: begin
          // The burst after the 32nd space is the stop burst.
          if (w_fall && (in_win(r_dur, 11'd28, 11'd84) || in_win(r_dur, 11'd140, 11'd200))) begin
            r_sr     <= {in_win(r_dur, 11'd140, 11'd200), r_sr[31:1]};
            r_bitcnt <= r_bitcnt + 6'd1;
            r_state  <= (r_bitcnt == 6'd31) ? STOP : BIT_BURST;
          end else if (w_edge || w_timeout) begin
            r_state <= IDLE;
            r_error <= 1'b1;
          end
        end
        STOP: begin
          if (w_rise && in_win(r_dur, 11'd40, 11'd72)) begin
            r_state <= IDLE;
            if (w_cmd_ok && (EXT_ADDR || w_addr_ok)) begin
              r_button     <= r_sr[23:16];
              r_addr       <= r_sr[7:0];
              r_valid      <= 1'b1;
              r_have_frame <= 1'b1;
            end else begin
              r_error <= 1'b1;
            end
          end else if (w_edge || w_timeout) begin
            r_state <= IDLE;
            r_error <= 1'b1;
          end
        end
        REPEAT_BURST: begin
          if (w_rise && in_win(r_dur, 11'd40, 11'd72)) begin
            r_state  <= IDLE;
            r_repeat <= r_have_frame;
          end else if (w_edge || w_timeout) begin
            r_state <= IDLE;
            r_error <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ir_button = r_button;
  assign ir_addr   = r_addr;
  assign ir_valid  = r_valid;
  assign ir_repeat = r_repeat;
  assign ir_error  = r_error;
  assign ir_busy   = (r_state != IDLE);

endmodule

// File: tb/tb_ir_nec_decoder.sv
// Bench for ir_nec_decoder: two instances (checked and extended address) share
// one IR line; CLK_HZ is scaled so that one duration tick equals one clock.
module tb_ir_nec_decoder;

  logic       clk;
  logic       reset;
  logic       IRDA_RXD;
  logic [7:0] btnM, addrM, btnE, addrE;
  logic       vM, rM, eM, busyM;
  logic       vE, rE, eE, busyE;

  int passCount  = 0;
  int totalCount = 0;
  int cntVM = 0, cntRM = 0, cntEM = 0, cntVE = 0, cntRE = 0, cntEE = 0;
  int overlapM = 0, overlapE = 0;

  ir_nec_decoder #(.CLK_HZ(100_000), .EXT_ADDR(1'b0)) dutM (
    .clk_50(clk), .reset(reset), .IRDA_RXD(IRDA_RXD),
    .ir_button(btnM), .ir_addr(addrM), .ir_valid(vM), .ir_repeat(rM),
    .ir_error(eM), .ir_busy(busyM)
  );

  ir_nec_decoder #(.CLK_HZ(100_000), .EXT_ADDR(1'b1)) dutE (
    .clk_50(clk), .reset(reset), .IRDA_RXD(IRDA_RXD),
    .ir_button(btnE), .ir_addr(addrE), .ir_valid(vE), .ir_repeat(rE),
    .ir_error(eE), .ir_busy(busyE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (vM) cntVM++;
    if (rM) cntRM++;
    if (eM) cntEM++;
    if (vE) cntVE++;
    if (rE) cntRE++;
    if (eE) cntEE++;
    if ((int'(vM) + int'(rM) + int'(eM)) > 1) overlapM++;
    if ((int'(vE) + int'(rE) + int'(eE)) > 1) overlapE++;
  end

  typedef struct {
    string      name;
    bit         isRepeat;
    logic [7:0] a, an, c, cn;
    int         sp0, sp1;
    int         expVM, expRM, expEM, expVE, expRE, expEE;
    logic [7:0] expBtnM, expAddrM, expBtnE, expAddrE;
  } vec_t;

  vec_t vecs[6];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Each call leaves the line at the level for exactly n clocks (drive at posedge+1).
  task automatic holdLevel(input logic level, input int n);
    IRDA_RXD = level;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sendFrame(input logic [31:0] word, input int nbits, input int sp0,
                           input int sp1, input bit doStop);
    holdLevel(1'b0, 901);
    holdLevel(1'b1, 451);
    for (int i = 0; i < nbits; i++) begin
      holdLevel(1'b0, 57);
      holdLevel(1'b1, word[i] ? sp1 : sp0);
    end
    if (doStop) begin
      holdLevel(1'b0, 57);
      holdLevel(1'b1, 60);
    end
  endtask

  task automatic sendRepeat();
    holdLevel(1'b0, 901);
    holdLevel(1'b1, 226);
    holdLevel(1'b0, 57);
    holdLevel(1'b1, 60);
  endtask

  task automatic applyStimulus(input vec_t v);
    int bVM, bRM, bEM, bVE, bRE, bEE;
    bVM = cntVM; bRM = cntRM; bEM = cntEM;
    bVE = cntVE; bRE = cntRE; bEE = cntEE;
    if (v.isRepeat) sendRepeat();
    else sendFrame({v.cn, v.c, v.an, v.a}, 32, v.sp0, v.sp1, 1'b1);
    checkOutput({v.name, " validM"}, cntVM - bVM, v.expVM);
    checkOutput({v.name, " repeatM"}, cntRM - bRM, v.expRM);
    checkOutput({v.name, " errorM"}, cntEM - bEM, v.expEM);
    checkOutput({v.name, " validE"}, cntVE - bVE, v.expVE);
    checkOutput({v.name, " repeatE"}, cntRE - bRE, v.expRE);
    checkOutput({v.name, " errorE"}, cntEE - bEE, v.expEE);
    checkOutput({v.name, " buttonM"}, 32'(btnM), 32'(v.expBtnM));
    checkOutput({v.name, " addrM"}, 32'(addrM), 32'(v.expAddrM));
    checkOutput({v.name, " buttonE"}, 32'(btnE), 32'(v.expBtnE));
    checkOutput({v.name, " addrE"}, 32'(addrE), 32'(v.expAddrE));
  endtask

  initial begin
    int n;
    int bEM, bEE, bVM, bVE;

    vecs[0] = '{"repeat after reset", 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 57, 170,
                0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[1] = '{"frame 00/16", 1'b0, 8'h00, 8'hFF, 8'h16, 8'hE9, 57, 170,
                1, 0, 0, 1, 0, 0, 8'h16, 8'h00, 8'h16, 8'h00};
    vecs[2] = '{"bad cmd inverse", 1'b0, 8'h00, 8'hFF, 8'h16, 8'hE8, 57, 170,
                0, 0, 1, 0, 0, 1, 8'h16, 8'h00, 8'h16, 8'h00};
    vecs[3] = '{"repeat after frame", 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 57, 170,
                0, 1, 0, 0, 1, 0, 8'h16, 8'h00, 8'h16, 8'h00};
    vecs[4] = '{"ext addr -15pct", 1'b0, 8'h12, 8'h34, 8'h5A, 8'hA5, 48, 144,
                0, 0, 1, 1, 0, 0, 8'h16, 8'h00, 8'h5A, 8'h12};
    vecs[5] = '{"ext addr +15pct", 1'b0, 8'h12, 8'h34, 8'h5A, 8'hA5, 65, 195,
                0, 0, 1, 1, 0, 0, 8'h16, 8'h00, 8'h5A, 8'h12};

    reset = 1'b1;
    IRDA_RXD = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("reset button", 32'(btnM), 32'h00);
    checkOutput("reset addr", 32'(addrM), 32'h00);
    checkOutput("reset strobes", 32'({vM, rM, eM, vE, rE, eE}), 32'h0);
    checkOutput("reset busyM", 32'(busyM), 32'h0);
    checkOutput("reset busyE", 32'(busyE), 32'h0);
    reset = 1'b0;
    holdLevel(1'b1, 50);

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

    // Leader burst too short: error on its rising edge.
    bEM = cntEM;
    holdLevel(1'b0, 300);
    checkOutput("short leader busy", 32'(busyM), 32'h1);
    holdLevel(1'b0, 301);
    holdLevel(1'b1, 20);
    checkOutput("short leader error", cntEM - bEM, 1);
    checkOutput("short leader busy after", 32'(busyM), 32'h0);
    holdLevel(1'b1, 100);

    // Leader held low: timeout once the duration passes 1000 ticks.
    bEM = cntEM;
    IRDA_RXD = 1'b0;
    n = 0;
    for (int k = 1; k <= 1300; k++) begin
      @(posedge clk);
      #1;
      if (eM) begin
        n = k;
        break;
      end
    end
    checkOutput("leader timeout latency in window", 32'(n >= 1000 && n <= 1010), 32'h1);
    checkOutput("timeout busy low", 32'(busyM), 32'h0);
    holdLevel(1'b0, 100);
    holdLevel(1'b1, 100);
    checkOutput("timeout single error", cntEM - bEM, 1);

    // A 1.0 ms bit space falls between the 0 and 1 windows.
    bEM = cntEM; bEE = cntEE; bVM = cntVM;
    sendFrame(32'hA55AED12, 2, 57, 170, 1'b0);
    holdLevel(1'b0, 57);
    holdLevel(1'b1, 101);
    holdLevel(1'b0, 57);
    holdLevel(1'b1, 300);
    checkOutput("bad space errorM", cntEM - bEM, 1);
    checkOutput("bad space errorE", cntEE - bEE, 1);
    checkOutput("bad space no valid", cntVM - bVM, 0);

    // Reset in the middle of a frame, then a complete frame.
    sendFrame(32'hBA45FB04, 10, 57, 170, 1'b0);
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("mid reset button", 32'(btnM), 32'h00);
    checkOutput("mid reset addr", 32'(addrE), 32'h00);
    checkOutput("mid reset busy", 32'(busyM), 32'h0);
    reset = 1'b0;
    holdLevel(1'b1, 50);
    bEM = cntEM; bVM = cntVM;
    sendFrame(32'hBA45FB04, 32, 57, 170, 1'b1);
    checkOutput("post reset valid", cntVM - bVM, 1);
    checkOutput("post reset error", cntEM - bEM, 0);
    checkOutput("post reset button", 32'(btnM), 32'h45);
    checkOutput("post reset addr", 32'(addrM), 32'h04);

    // Back-to-back frames with only the stop tail between them.
    bVM = cntVM; bVE = cntVE;
    sendFrame(32'hFD02FE01, 32, 57, 170, 1'b1);
    sendFrame(32'hFB04FC03, 32, 57, 170, 1'b1);
    checkOutput("back-to-back validM", cntVM - bVM, 2);
    checkOutput("back-to-back validE", cntVE - bVE, 2);
    checkOutput("back-to-back button", 32'(btnM), 32'h04);
    checkOutput("back-to-back addr", 32'(addrM), 32'h03);

    checkOutput("strobe overlap M", overlapM, 0);
    checkOutput("strobe overlap E", overlapE, 0);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
